// File: rtl/csr_regfile.sv
// Machine-mode CSR register file shared by the execute stage and the interrupt controller.
// Two combinational read ports, one arbitrated write path, 64-bit mcycle/minstret counters.
module csr_regfile #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter logic [DATA_W-1:0] MTVEC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_wr_en_i,
    input  logic [ADDR_W-1:0] ex_wr_addr_i,
    input  logic [DATA_W-1:0] ex_wr_data_i,
    input  logic [ADDR_W-1:0] ex_rd_addr_i,
    output logic [DATA_W-1:0] ex_rd_data_o,
    input  logic              clint_wr_en_i,
    input  logic [ADDR_W-1:0] clint_wr_addr_i,
    input  logic [DATA_W-1:0] clint_wr_data_i,
    input  logic [ADDR_W-1:0] clint_rd_addr_i,
    output logic [DATA_W-1:0] clint_rd_data_o,
    input  logic              wr_privilege_en_i,
    input  logic [1:0]        wr_privilege_i,
    input  logic              inst_retire_i,
    output logic [DATA_W-1:0] csr_mtvec_o,
    output logic [DATA_W-1:0] csr_mepc_o,
    output logic [DATA_W-1:0] csr_mstatus_o,
    output logic [DATA_W-1:0] csr_mie_o,
    output logic [1:0]        privilege_o
);

    localparam int CNT_W = 2 * DATA_W;

    localparam logic [11:0] CSR_MSTATUS    = 12'h300;
    localparam logic [11:0] CSR_MIE        = 12'h304;
    localparam logic [11:0] CSR_MTVEC      = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH   = 12'h340;
    localparam logic [11:0] CSR_MEPC       = 12'h341;
    localparam logic [11:0] CSR_MCAUSE     = 12'h342;
    localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
    localparam logic [11:0] CSR_CYCLE      = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH     = 12'hC80;
    localparam logic [11:0] CSR_INSTRET    = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH   = 12'hC82;

    localparam logic [DATA_W-1:0] MIE_MASK = DATA_W'(32'h0000_0888);
    localparam logic [1:0]        PRIV_U   = 2'b00;
    localparam logic [1:0]        PRIV_M   = 2'b11;

    logic              mstatus_mie;
    logic              mstatus_mpie;
    logic [1:0]        mstatus_mpp;
    logic [DATA_W-1:0] mie_q;
    logic [DATA_W-1:0] mtvec_q;
    logic [DATA_W-1:0] mscratch_q;
    logic [DATA_W-1:0] mepc_q;
    logic [DATA_W-1:0] mcause_q;
    logic [CNT_W-1:0]  mcycle_q;
    logic [CNT_W-1:0]  minstret_q;
    logic [1:0]        priv_q;

    logic              wr_en;
    logic [11:0]       wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] mstatus_val;
    logic [CNT_W-1:0]  mcycle_nxt;
    logic [CNT_W-1:0]  minstret_nxt;

    // The interrupt controller owns the write path whenever it asserts; ex is dropped.
    assign wr_en   = clint_wr_en_i | ex_wr_en_i;
    assign wr_addr = clint_wr_en_i ? clint_wr_addr_i[11:0] : ex_wr_addr_i[11:0];
    assign wr_data = clint_wr_en_i ? clint_wr_data_i : ex_wr_data_i;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ex_wr_addr_i[ADDR_W-1:12], ex_rd_addr_i[ADDR_W-1:12],
                                clint_wr_addr_i[ADDR_W-1:12], clint_rd_addr_i[ADDR_W-1:12]};

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[3]     = mstatus_mie;
        mstatus_val[7]     = mstatus_mpie;
        mstatus_val[12:11] = mstatus_mpp;
    end

    always_comb begin
        mcycle_nxt = mcycle_q + CNT_W'(1);
        if (wr_en && wr_addr == CSR_MCYCLE)
            mcycle_nxt = {mcycle_q[CNT_W-1:DATA_W], wr_data};
        else if (wr_en && wr_addr == CSR_MCYCLEH)
            mcycle_nxt = {wr_data, mcycle_q[DATA_W-1:0]};
    end

    always_comb begin
        minstret_nxt = minstret_q;
        if (wr_en && wr_addr == CSR_MINSTRET)
            minstret_nxt = {minstret_q[CNT_W-1:DATA_W], wr_data};
        else if (wr_en && wr_addr == CSR_MINSTRETH)
            minstret_nxt = {wr_data, minstret_q[DATA_W-1:0]};
        else if (inst_retire_i)
            minstret_nxt = minstret_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mstatus_mpp  <= PRIV_M;
            mie_q        <= '0;
            mtvec_q      <= {MTVEC_RESET[DATA_W-1:2], 2'b00};
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mcycle_q     <= '0;
            minstret_q   <= '0;
            priv_q       <= PRIV_M;
        end else begin
            mcycle_q   <= mcycle_nxt;
            minstret_q <= minstret_nxt;
            if (wr_en) begin
                case (wr_addr)
                    CSR_MSTATUS: begin
                        mstatus_mie  <= wr_data[3];
                        mstatus_mpie <= wr_data[7];
                        // MPP only accepts U or M; S/H encodings keep the old value.
                        if (wr_data[12:11] == PRIV_U || wr_data[12:11] == PRIV_M)
                            mstatus_mpp <= wr_data[12:11];
                    end
                    CSR_MIE:      mie_q      <= wr_data & MIE_MASK;
                    CSR_MTVEC:    mtvec_q    <= {wr_data[DATA_W-1:2], 2'b00};
                    CSR_MSCRATCH: mscratch_q <= wr_data;
                    CSR_MEPC:     mepc_q     <= {wr_data[DATA_W-1:2], 2'b00};
                    CSR_MCAUSE:   mcause_q   <= wr_data;
                    default: ;
                endcase
            end
            if (wr_privilege_en_i &&
                (wr_privilege_i == PRIV_U || wr_privilege_i == PRIV_M))
                priv_q <= wr_privilege_i;
        end
    end

    function automatic logic [DATA_W-1:0] csr_read(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS:                 return mstatus_val;
            CSR_MIE:                     return mie_q;
            CSR_MTVEC:                   return mtvec_q;
            CSR_MSCRATCH:                return mscratch_q;
            CSR_MEPC:                    return mepc_q;
            CSR_MCAUSE:                  return mcause_q;
            CSR_MCYCLE,   CSR_CYCLE:     return mcycle_q[DATA_W-1:0];
            CSR_MCYCLEH,  CSR_CYCLEH:    return mcycle_q[CNT_W-1:DATA_W];
            CSR_MINSTRET, CSR_INSTRET:   return minstret_q[DATA_W-1:0];
            CSR_MINSTRETH, CSR_INSTRETH: return minstret_q[CNT_W-1:DATA_W];
            default:                     return '0;
        endcase
    endfunction

    always_comb begin
        ex_rd_data_o    = csr_read(ex_rd_addr_i[11:0]);
        clint_rd_data_o = csr_read(clint_rd_addr_i[11:0]);
    end

    assign csr_mtvec_o   = mtvec_q;
    assign csr_mepc_o    = mepc_q;
    assign csr_mstatus_o = mstatus_val;
    assign csr_mie_o     = mie_q;
    assign privilege_o   = priv_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed test of csr_regfile: reset values, write arbitration, field masks,
// counter load/carry/wrap, privilege load and asynchronous reset.
module tb_csr_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_wr_en_i;
    logic [31:0] ex_wr_addr_i;
    logic [31:0] ex_wr_data_i;
    logic [31:0] ex_rd_addr_i;
    logic [31:0] ex_rd_data_o;
    logic        clint_wr_en_i;
    logic [31:0] clint_wr_addr_i;
    logic [31:0] clint_wr_data_i;
    logic [31:0] clint_rd_addr_i;
    logic [31:0] clint_rd_data_o;
    logic        wr_privilege_en_i;
    logic [1:0]  wr_privilege_i;
    logic        inst_retire_i;
    logic [31:0] csr_mtvec_o;
    logic [31:0] csr_mepc_o;
    logic [31:0] csr_mstatus_o;
    logic [31:0] csr_mie_o;
    logic [1:0]  privilege_o;

    int n_checks = 0;
    int n_errors = 0;

    csr_regfile #(.DATA_W(32), .ADDR_W(32), .MTVEC_RESET(32'h0000_0000)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_wr_en_i       (ex_wr_en_i),
        .ex_wr_addr_i     (ex_wr_addr_i),
        .ex_wr_data_i     (ex_wr_data_i),
        .ex_rd_addr_i     (ex_rd_addr_i),
        .ex_rd_data_o     (ex_rd_data_o),
        .clint_wr_en_i    (clint_wr_en_i),
        .clint_wr_addr_i  (clint_wr_addr_i),
        .clint_wr_data_i  (clint_wr_data_i),
        .clint_rd_addr_i  (clint_rd_addr_i),
        .clint_rd_data_o  (clint_rd_data_o),
        .wr_privilege_en_i(wr_privilege_en_i),
        .wr_privilege_i   (wr_privilege_i),
        .inst_retire_i    (inst_retire_i),
        .csr_mtvec_o      (csr_mtvec_o),
        .csr_mepc_o       (csr_mepc_o),
        .csr_mstatus_o    (csr_mstatus_o),
        .csr_mie_o        (csr_mie_o),
        .privilege_o      (privilege_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_wr_en_i        = 1'b0;
        clint_wr_en_i     = 1'b0;
        wr_privilege_en_i = 1'b0;
        inst_retire_i     = 1'b0;
    endtask

    task automatic ex_wr(input logic [31:0] addr, input logic [31:0] data);
        ex_wr_en_i   = 1'b1;
        ex_wr_addr_i = addr;
        ex_wr_data_i = data;
    endtask

    task automatic clint_wr(input logic [31:0] addr, input logic [31:0] data);
        clint_wr_en_i   = 1'b1;
        clint_wr_addr_i = addr;
        clint_wr_data_i = data;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        ex_rd_addr_i    = addr;
        clint_rd_addr_i = addr;
        #1;
        chk({tag, "_ex"}, ex_rd_data_o, exp);
        chk({tag, "_clint"}, clint_rd_data_o, exp);
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        ex_wr_addr_i = '0; ex_wr_data_i = '0; ex_rd_addr_i = '0;
        clint_wr_addr_i = '0; clint_wr_data_i = '0; clint_rd_addr_i = '0;
        wr_privilege_i = 2'b00;
        #1 rst_n = 1'b0;
        #1;
        rd_chk("rst_mstatus", 32'h300, 32'h0000_1800);
        rd_chk("rst_mtvec", 32'h305, 32'h0);
        rd_chk("rst_mepc", 32'h341, 32'h0);
        chk("rst_priv", {30'b0, privilege_o}, 32'h3);
        chk("rst_mstatus_o", csr_mstatus_o, 32'h0000_1800);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // mtvec low bits forced to zero; no forwarding before the edge
        ex_wr(32'h305, 32'h8000_0103);
        rd_chk("mtvec_prewrite", 32'h305, 32'h0);
        tick();
        idle();
        chk("mtvec_o", csr_mtvec_o, 32'h8000_0100);
        rd_chk("mtvec_rd", 32'h305, 32'h8000_0100);

        // clint wins; ex write discarded even to a different address
        clint_wr(32'h341, 32'h0000_0100);
        ex_wr(32'h340, 32'h0000_0055);
        tick();
        idle();
        chk("mepc_o", csr_mepc_o, 32'h0000_0100);
        rd_chk("mscratch_kept", 32'h340, 32'h0);

        // mcycle carry from lo into hi
        ex_wr(32'hB00, 32'hFFFF_FFFE);
        tick();
        ex_wr(32'hB80, 32'h0);
        tick();
        idle();
        rd_chk("mcycle_lo_held", 32'hB00, 32'hFFFF_FFFE);
        rd_chk("mcycle_hi_wr", 32'hB80, 32'h0);
        tick();
        rd_chk("mcycle_lo_inc", 32'hB00, 32'hFFFF_FFFF);
        tick();
        rd_chk("mcycle_lo_wrap", 32'hB00, 32'h0);
        rd_chk("cycleh_alias", 32'hC80, 32'h1);

        // read-only alias write ignored, counter keeps running
        ex_wr(32'hC00, 32'h5);
        tick();
        idle();
        rd_chk("cycle_ro_wr", 32'hB00, 32'h1);
        tick();
        rd_chk("cycle_next", 32'hC00, 32'h2);

        // minstret: write wins over retire, then counts retires only
        inst_retire_i = 1'b1;
        ex_wr(32'hB02, 32'h5);
        tick();
        idle();
        rd_chk("minstret_wr", 32'hB02, 32'h5);
        inst_retire_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        inst_retire_i = 1'b0;
        tick();
        tick();
        rd_chk("instret_cnt", 32'hC02, 32'h8);
        ex_wr(32'hB02, 32'hFFFF_FFFF);
        tick();
        ex_wr(32'hB82, 32'hFFFF_FFFF);
        tick();
        idle();
        rd_chk("minstreth_wr", 32'hB82, 32'hFFFF_FFFF);
        inst_retire_i = 1'b1;
        tick();
        idle();
        rd_chk("minstret_wrap_lo", 32'hB02, 32'h0);
        rd_chk("minstret_wrap_hi", 32'hB82, 32'h0);

        // mstatus write and privilege load in the same cycle
        clint_wr(32'h300, 32'h0000_0088);
        wr_privilege_en_i = 1'b1;
        wr_privilege_i    = 2'b00;
        tick();
        idle();
        chk("mstatus_88", csr_mstatus_o, 32'h0000_0088);
        chk("priv_u", {30'b0, privilege_o}, 32'h0);
        clint_wr(32'h300, 32'h0000_1088);
        tick();
        idle();
        chk("mpp_warl", csr_mstatus_o, 32'h0000_0088);
        ex_wr(32'h300, 32'hFFFF_FFFF);
        wr_privilege_en_i = 1'b1;
        wr_privilege_i    = 2'b10;
        tick();
        idle();
        chk("mstatus_mask", csr_mstatus_o, 32'h0000_1888);
        chk("priv_ignored", {30'b0, privilege_o}, 32'h0);
        wr_privilege_en_i = 1'b1;
        wr_privilege_i    = 2'b11;
        tick();
        idle();
        chk("priv_m", {30'b0, privilege_o}, 32'h3);

        // mie mask, mcause, unmapped and high-address-bit decode
        ex_wr(32'h304, 32'hFFFF_FFFF);
        tick();
        ex_wr(32'h342, 32'hDEAD_BEEF);
        tick();
        ex_wr(32'h7C0, 32'h1234_5678);
        tick();
        idle();
        chk("mie_mask", csr_mie_o, 32'h0000_0888);
        rd_chk("mcause", 32'h342, 32'hDEAD_BEEF);
        rd_chk("unmapped", 32'h7C0, 32'h0);
        rd_chk("addr_hi_bits", 32'hABCD_E300, 32'h0000_1888);

        // asynchronous reset with a write pending
        ex_wr(32'h305, 32'h0000_0040);
        #2 rst_n = 1'b0;
        #1;
        idle();
        chk("arst_mtvec", csr_mtvec_o, 32'h0);
        chk("arst_mstatus", csr_mstatus_o, 32'h0000_1800);
        chk("arst_mie", csr_mie_o, 32'h0);
        chk("arst_priv", {30'b0, privilege_o}, 32'h3);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_write_lost", csr_mtvec_o, 32'h0);
        rd_chk("arst_mcycle", 32'hB00, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, expected finish before 20000");
        $fatal(1);
    end

endmodule
